// File: rtl/lc2k_pkg.sv
// Shared sizes and types for the LC2K register file slice.
package lc2k_pkg;

   localparam int WORD_W   = 32;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [WORD_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = 3'd0;

endpackage

// File: rtl/lc2k_reg_scoreboard.sv
// Per-register busy tracking; exports effective busy (busy minus same-cycle writeback).
module lc2k_reg_scoreboard
   import lc2k_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                write_en,
   input  reg_idx_t            write_reg,
   input  logic                issue_en,
   input  reg_idx_t            issue_reg,
   output logic [NUM_REGS-1:0] eff_busy
);

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;

   // Next busy state: issue sets, writeback clears, set wins; r0 never busy.
   always_comb begin
      busy_nxt_s = busy_r;
      eff_busy   = busy_r;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (write_en && (write_reg == reg_idx_t'(i))) begin
            busy_nxt_s[i] = 1'b0;
            eff_busy[i]   = 1'b0;
         end else begin
            busy_nxt_s[i] = busy_r[i];
         end
         if (issue_en && (issue_reg == reg_idx_t'(i)) && (issue_reg != REG_ZERO)) begin
            busy_nxt_s[i] = 1'b1;
         end else begin
            busy_nxt_s[i] = busy_nxt_s[i];
         end
      end
      busy_nxt_s[0] = 1'b0;
      eff_busy[0]   = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

endmodule

// File: rtl/lc2k_reg_file.sv
// LC2K architectural register file: two registered read ports with write bypass
// and a busy scoreboard that raises hazard instead of performing a stale read.
module lc2k_reg_file
   import lc2k_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     rd_en,
   input  reg_idx_t read_reg_a,
   input  reg_idx_t read_reg_b,
   output word_t    read_data_a,
   output word_t    read_data_b,
   output logic     read_valid,
   output logic     hazard,
   input  logic     write_en,
   input  reg_idx_t write_reg,
   input  word_t    write_data,
   input  logic     issue_en,
   input  reg_idx_t issue_reg
);

   word_t               regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] eff_busy_s;
   word_t               rd_a_s;
   word_t               rd_b_s;
   logic                wr_ok_s;

   function automatic word_t sel_read(input reg_idx_t idx, input logic wr_ok,
                                      input reg_idx_t wr, input word_t wd,
                                      input word_t stored);
      word_t val;
      if (idx == REG_ZERO) begin
         val = 32'h0000_0000;
      end else if (wr_ok && (wr == idx)) begin
         val = wd;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   lc2k_reg_scoreboard u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .write_en  (write_en),
      .write_reg (write_reg),
      .issue_en  (issue_en),
      .issue_reg (issue_reg),
      .eff_busy  (eff_busy_s)
   );

   // Hazard check and bypassed operand selection.
   always_comb begin
      wr_ok_s = write_en && (write_reg != REG_ZERO);
      hazard  = rd_en & (eff_busy_s[read_reg_a] | eff_busy_s[read_reg_b]);
      rd_a_s  = sel_read(read_reg_a, wr_ok_s, write_reg, write_data, regs_r[read_reg_a]);
      rd_b_s  = sel_read(read_reg_b, wr_ok_s, write_reg, write_data, regs_r[read_reg_b]);
   end

   // Register storage and registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
         read_data_a <= '0;
         read_data_b <= '0;
         read_valid  <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            regs_r[write_reg] <= write_data;
         end
         if (rd_en && !hazard) begin
            read_data_a <= rd_a_s;
            read_data_b <= rd_b_s;
            read_valid  <= 1'b1;
         end else begin
            read_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Self-checking bench: directed vectors, a behavioural array model checked every
// cycle, plus literal expectations after key steps.
module tb_lc2k_reg_file;
   import lc2k_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     rd_en;
   reg_idx_t read_reg_a, read_reg_b;
   word_t    read_data_a, read_data_b;
   logic     read_valid, hazard;
   logic     write_en;
   reg_idx_t write_reg;
   word_t    write_data;
   logic     issue_en;
   reg_idx_t issue_reg;

   int n_checks = 0;
   int n_pass   = 0;
   logic cmp_on = 1'b0;
   logic last_hz;

   // model state
   logic [31:0] m_reg [8];
   bit          m_busy [8];
   logic [31:0] m_a, m_b;
   logic        m_valid;

   lc2k_reg_file dut (
      .clk(clk), .reset(reset), .rd_en(rd_en),
      .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
      .read_data_a(read_data_a), .read_data_b(read_data_b),
      .read_valid(read_valid), .hazard(hazard),
      .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
      .issue_en(issue_en), .issue_reg(issue_reg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_eff_busy(input int x);
      return m_busy[x] && !(write_en && int'(write_reg) == x);
   endfunction

   function automatic bit m_hazard();
      return rd_en && (m_eff_busy(int'(read_reg_a)) || m_eff_busy(int'(read_reg_b)));
   endfunction

   function automatic logic [31:0] m_read(input int x);
      if (x == 0) return 32'h0;
      if (write_en && int'(write_reg) == x) return write_data;
      return m_reg[x];
   endfunction

   // Model: apply the architectural rules at each rising edge.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin m_reg[i] = 32'h0; m_busy[i] = 1'b0; end
         m_a = 32'h0; m_b = 32'h0; m_valid = 1'b0;
      end else begin
         if (rd_en && !m_hazard()) begin
            m_a = m_read(int'(read_reg_a));
            m_b = m_read(int'(read_reg_b));
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (write_en && write_reg != 3'd0) begin
            m_reg[write_reg] = write_data;
            m_busy[write_reg] = 1'b0;
         end
         if (issue_en && issue_reg != 3'd0) m_busy[issue_reg] = 1'b1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_valid",  {31'd0, read_valid}, {31'd0, m_valid});
         chk("model_data_a", read_data_a, m_a);
         chk("model_data_b", read_data_b, m_b);
         chk("model_hazard", {31'd0, hazard}, {31'd0, m_hazard()});
      end
   end

   task automatic step(input logic rst, input logic rd, input int a, input int b,
                       input logic we, input int wr, input logic [31:0] wd,
                       input logic ie, input int ir);
      reset = rst; rd_en = rd;
      read_reg_a = reg_idx_t'(a); read_reg_b = reg_idx_t'(b);
      write_en = we; write_reg = reg_idx_t'(wr); write_data = wd;
      issue_en = ie; issue_reg = reg_idx_t'(ir);
      @(negedge clk);
      last_hz = hazard;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b0, 0);
   endtask

   initial begin
      reset = 1'b1; rd_en = 1'b0; read_reg_a = 3'd0; read_reg_b = 3'd0;
      write_en = 1'b0; write_reg = 3'd0; write_data = 32'h0;
      issue_en = 1'b0; issue_reg = 3'd0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b0, 0);
      cmp_on = 1'b1;
      chk("reset_valid", {31'd0, read_valid}, 32'd0);
      chk("reset_data_a", read_data_a, 32'h0);

      step(1'b0, 1'b1, 0, 7, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("r0r7_valid", {31'd0, read_valid}, 32'd1);
      chk("r0r7_a", read_data_a, 32'h0);
      chk("r0r7_b", read_data_b, 32'h0);

      step(1'b0, 1'b0, 0, 0, 1'b1, 3, 32'h0000_00AA, 1'b0, 0);
      chk("idle_valid", {31'd0, read_valid}, 32'd0);
      step(1'b0, 1'b1, 3, 0, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("r3_a", read_data_a, 32'h0000_00AA);
      chk("r3_b", read_data_b, 32'h0);

      step(1'b0, 1'b0, 0, 0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0);
      step(1'b0, 1'b1, 0, 3, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("r0_write_ignored", read_data_a, 32'h0);
      chk("r3_on_b", read_data_b, 32'h0000_00AA);

      step(1'b0, 1'b1, 5, 5, 1'b1, 5, 32'h0000_1234, 1'b0, 0);
      chk("bypass_hz", {31'd0, last_hz}, 32'd0);
      chk("bypass_a", read_data_a, 32'h0000_1234);
      chk("bypass_b", read_data_b, 32'h0000_1234);
      idle();
      chk("hold_valid", {31'd0, read_valid}, 32'd0);
      chk("hold_a", read_data_a, 32'h0000_1234);

      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b1, 2);
      step(1'b0, 1'b1, 2, 0, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("busy2_hz", {31'd0, last_hz}, 32'd1);
      chk("busy2_valid", {31'd0, read_valid}, 32'd0);
      chk("busy2_hold_a", read_data_a, 32'h0000_1234);
      step(1'b0, 1'b1, 2, 2, 1'b1, 2, 32'h0000_0077, 1'b0, 0);
      chk("wb2_hz", {31'd0, last_hz}, 32'd0);
      chk("wb2_a", read_data_a, 32'h0000_0077);
      chk("wb2_b", read_data_b, 32'h0000_0077);
      step(1'b0, 1'b1, 2, 0, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("r2_again", read_data_a, 32'h0000_0077);

      step(1'b0, 1'b0, 0, 0, 1'b1, 4, 32'h0000_0009, 1'b1, 4);
      step(1'b0, 1'b1, 4, 4, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("setwins_hz", {31'd0, last_hz}, 32'd1);
      chk("setwins_hold", read_data_a, 32'h0000_0077);
      step(1'b0, 1'b0, 0, 0, 1'b1, 4, 32'h0000_000A, 1'b0, 0);
      step(1'b0, 1'b1, 4, 0, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("r4_clear_hz", {31'd0, last_hz}, 32'd0);
      chk("r4_data", read_data_a, 32'h0000_000A);

      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 32'h0, 1'b1, 6);
      step(1'b1, 1'b1, 3, 1, 1'b1, 1, 32'h0000_0055, 1'b1, 7);
      chk("rst_drop_valid", {31'd0, read_valid}, 32'd0);
      chk("rst_data_a", read_data_a, 32'h0);
      step(1'b0, 1'b1, 6, 1, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("after_rst_hz", {31'd0, last_hz}, 32'd0);
      chk("after_rst_valid", {31'd0, read_valid}, 32'd1);
      chk("after_rst_r6", read_data_a, 32'h0);
      chk("rst_write_dropped", read_data_b, 32'h0);
      step(1'b0, 1'b1, 7, 3, 1'b0, 0, 32'h0, 1'b0, 0);
      chk("rst_issue_dropped", {31'd0, last_hz}, 32'd0);
      chk("r3_cleared", read_data_b, 32'h0);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
